scan_reg_bank: RTL and testbench

- Parametrised multi-bit scan register: WIDTH scannable flops with enable, async reset, QN outputs, split into NCHAIN equal scan chains.
- Generalises the single-bit scan flop cells to a register bank plus a per-bank shift counter that flags a completed chain load/unload.
- Used by DFT-inserted datapaths wherever a banked scan register with load-complete indication is needed.

---
 rtl/scan_reg_bank.sv | 82 ++++++++
 tb/tb_scan_reg_bank.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_reg_bank.sv
// Banked scan register: WIDTH flops split into NCHAIN equal shift chains,
// with a shared shift counter that pulses SDONE after each full L-bit chain shift.
module scan_reg_bank #(
    parameter int unsigned           WIDTH   = 8,
    parameter int unsigned           NCHAIN  = 2,
    parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic [WIDTH-1:0]  D,
    input  logic              EN,
    input  logic              SE,
    input  logic [NCHAIN-1:0] SI,
    output logic [WIDTH-1:0]  Q,
    output logic [WIDTH-1:0]  QN,
    output logic [NCHAIN-1:0] SO,
    output logic              SDONE
);

    localparam int unsigned   L    = WIDTH / NCHAIN;
    localparam int unsigned   CW   = (L > 1) ? $clog2(L) : 1;
    localparam logic [CW-1:0] LAST = CW'(L - 1);

    logic [WIDTH-1:0]  r_q;
    logic [CW-1:0]     r_cnt;
    logic              r_sdone;
    logic [WIDTH-1:0]  w_shift;
    logic [NCHAIN-1:0] w_so;

    // Each chain moves one bit towards its MSB; SI enters at the chain LSB.
    always_comb begin
        w_shift = r_q;
        for (int unsigned c = 0; c < NCHAIN; c++) begin
            w_shift[c*L] = SI[c];
            for (int unsigned k = 1; k < L; k++) begin
                w_shift[c*L+k] = r_q[c*L+k-1];
            end
        end
    end

    always_comb begin
        w_so = '0;
        for (int unsigned c = 0; c < NCHAIN; c++) begin
            w_so[c] = r_q[c*L+L-1];
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_q <= RST_VAL;
        end else if (SE) begin
            r_q <= w_shift;
        end else if (EN) begin
            r_q <= D;
        end
    end

    // Any cycle without SE restarts the count, so SDONE marks L back-to-back shifts.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_cnt   <= '0;
            r_sdone <= 1'b0;
        end else if (SE) begin
            if (r_cnt == LAST) begin
                r_cnt   <= '0;
                r_sdone <= 1'b1;
            end else begin
                r_cnt   <= r_cnt + CW'(1);
                r_sdone <= 1'b0;
            end
        end else begin
            r_cnt   <= '0;
            r_sdone <= 1'b0;
        end
    end

    assign Q     = r_q;
    assign QN    = ~r_q;
    assign SO    = w_so;
    assign SDONE = r_sdone;

endmodule

// File: tb/tb_scan_reg_bank.sv
// Self-checking bench for scan_reg_bank (WIDTH=8, NCHAIN=2, L=4) against a
// chain-level integer model: directed scenarios followed by randomized traffic.
module tb_scan_reg_bank;

    localparam int W = 8;
    localparam int N = 2;
    localparam int L = W / N;

    logic         CK;
    logic         RST;
    logic [W-1:0] D;
    logic         EN;
    logic         SE;
    logic [N-1:0] SI;
    logic [W-1:0] Q;
    logic [W-1:0] QN;
    logic [N-1:0] SO;
    logic         SDONE;

    logic clk_run;
    int   checks;
    int   failures;

    // Model: each chain is an integer in 0..2^L-1, plus a run length of consecutive shifts.
    int   m_chain[N];
    int   m_run;
    logic m_sdone;

    scan_reg_bank #(
        .WIDTH  (W),
        .NCHAIN (N),
        .RST_VAL(8'h00)
    ) dut (
        .CK   (CK),
        .RST  (RST),
        .D    (D),
        .EN   (EN),
        .SE   (SE),
        .SI   (SI),
        .Q    (Q),
        .QN   (QN),
        .SO   (SO),
        .SDONE(SDONE)
    );

    initial CK = 1'b0;
    always begin
        #5;
        if (clk_run) CK = ~CK;
    end

    task automatic model_reset();
        for (int c = 0; c < N; c++) m_chain[c] = 0;
        m_run   = 0;
        m_sdone = 1'b0;
    endtask

    function automatic logic [W-1:0] model_q();
        int v;
        v = 0;
        for (int c = 0; c < N; c++) v = v + m_chain[c] * (1 << (c * L));
        return W'(v);
    endfunction

    function automatic logic [2*W+N:0] model_vec();
        logic [N-1:0] so;
        for (int c = 0; c < N; c++) so[c] = ((m_chain[c] / (1 << (L - 1))) % 2) == 1;
        return {model_q(), ~model_q(), so, m_sdone};
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        @(posedge CK);
        if (RST) begin
            model_reset();
        end else if (SE) begin
            for (int c = 0; c < N; c++)
                m_chain[c] = (m_chain[c] * 2 + int'(SI[c])) % (1 << L);
            m_run   = m_run + 1;
            m_sdone = (m_run % L) == 0;
        end else begin
            if (EN)
                for (int c = 0; c < N; c++) m_chain[c] = (int'(D) / (1 << (c * L))) % (1 << L);
            m_run   = 0;
            m_sdone = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        RST = 1'b0; SE = 1'b0; EN = 1'b0; D = '0; SI = '0;
        #2;
        RST = 1'b1;
        #2;
        checks++;
        if ({Q, QN, SO, SDONE} !== {8'h00, 8'hFF, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL reset_no_clock: Q=%h QN=%h SO=%b SDONE=%b required Q=00 QN=FF SO=00 SDONE=0",
                     Q, QN, SO, SDONE);
        end
        model_reset();
        clk_run = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic test_load_hold();
        SE = 1'b0; EN = 1'b1; D = 8'hA5;
        tick();
        checks++;
        if ({Q, QN} !== {8'hA5, 8'h5A} || {Q, QN, SO, SDONE} !== model_vec()) begin
            failures++;
            $display("FAIL load: Q=%h QN=%h SO=%b SDONE=%b required %h", Q, QN, SO, SDONE, model_vec());
        end
        EN = 1'b0; D = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (Q !== 8'hA5 || {Q, QN, SO, SDONE} !== model_vec()) begin
                failures++;
                $display("FAIL hold: Q=%h QN=%h SO=%b SDONE=%b required %h", Q, QN, SO, SDONE, model_vec());
            end
        end
    endtask

    task automatic test_shift_seq();
        logic [3:0] so0_exp;
        so0_exp = 4'b1101;
        SE = 1'b1; EN = 1'b1; D = 8'h00; SI = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({Q, QN, SO, SDONE} !== model_vec() || SO[0] !== so0_exp[i] || SDONE !== (i == 3)) begin
                failures++;
                $display("FAIL shift_seq[%0d]: Q=%h QN=%h SO=%b SDONE=%b required %h SO0=%b",
                         i, Q, QN, SO, SDONE, model_vec(), so0_exp[i]);
            end
        end
        SE = 1'b0; EN = 1'b0;
        tick();
        checks++;
        if (SDONE !== 1'b0 || {Q, QN, SO, SDONE} !== model_vec()) begin
            failures++;
            $display("FAIL shift_seq_end: Q=%h SDONE=%b required %h", Q, SDONE, model_vec());
        end
    endtask

    task automatic test_se_gap();
        int pulses;
        logic [6:0] se_pat;
        pulses = 0;
        se_pat = 7'b1111011;
        EN = 1'b0;
        for (int i = 0; i < 7; i++) begin
            SE = se_pat[i];
            SI = N'($urandom);
            tick();
            if (SDONE === 1'b1) pulses++;
            checks++;
            if ({Q, QN, SO, SDONE} !== model_vec()) begin
                failures++;
                $display("FAIL se_gap[%0d]: Q=%h SO=%b SDONE=%b required %h", i, Q, SO, SDONE, model_vec());
            end
        end
        checks++;
        if (pulses !== 1 || SDONE !== 1'b1) begin
            failures++;
            $display("FAIL se_gap_pulses: pulses=%0d last_sdone=%b required pulses=1 last_sdone=1", pulses, SDONE);
        end
        SE = 1'b0;
        tick();
    endtask

    task automatic test_continuous();
        logic [11:0] mask;
        mask = '0;
        SE = 1'b1; EN = 1'b1;
        for (int i = 0; i < 12; i++) begin
            SI = N'($urandom);
            D  = W'($urandom);
            tick();
            mask[i] = SDONE;
            checks++;
            if ({Q, QN, SO, SDONE} !== model_vec()) begin
                failures++;
                $display("FAIL continuous[%0d]: Q=%h SO=%b SDONE=%b required %h", i, Q, SO, SDONE, model_vec());
            end
        end
        checks++;
        if (mask !== 12'b1000_1000_1000) begin
            failures++;
            $display("FAIL continuous_pulses: mask=%b required 100010001000", mask);
        end
        SE = 1'b0; EN = 1'b0;
        tick();
    endtask

    task automatic test_async_reset_mid_shift();
        SE = 1'b1; EN = 1'b0; SI = 2'b11;
        tick();
        tick();
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        checks++;
        if ({Q, QN, SO, SDONE} !== {8'h00, 8'hFF, 2'b00, 1'b0}) begin
            failures++;
            $display("FAIL async_reset: Q=%h QN=%h SO=%b SDONE=%b required 00 FF 00 0", Q, QN, SO, SDONE);
        end
        tick();
        checks++;
        if (Q !== 8'h00 || SDONE !== 1'b0) begin
            failures++;
            $display("FAIL reset_held: Q=%h SDONE=%b required Q=00 SDONE=0", Q, SDONE);
        end
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({Q, QN, SO, SDONE} !== model_vec() || SDONE !== (i == 3)) begin
                failures++;
                $display("FAIL post_reset_shift[%0d]: Q=%h SO=%b SDONE=%b required %h", i, Q, SO, SDONE, model_vec());
            end
        end
        checks++;
        if (Q !== 8'hFF) begin
            failures++;
            $display("FAIL post_reset_fill: Q=%h required FF", Q);
        end
        SE = 1'b0;
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            SE  = $urandom_range(0, 3) != 0;
            EN  = $urandom_range(0, 1) == 1;
            D   = W'($urandom);
            SI  = N'($urandom);
            RST = $urandom_range(0, 40) == 0;
            if (RST) begin
                #1;
                model_reset();
                checks++;
                if ({Q, QN, SO, SDONE} !== model_vec()) begin
                    failures++;
                    $display("FAIL random_async_reset[%0d]: Q=%h SDONE=%b required %h", i, Q, SDONE, model_vec());
                end
            end
            tick();
            RST = 1'b0;
            checks++;
            if ({Q, QN, SO, SDONE} !== model_vec()) begin
                failures++;
                $display("FAIL random[%0d]: Q=%h QN=%h SO=%b SDONE=%b required %h",
                         i, Q, QN, SO, SDONE, model_vec());
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clk_run  = 1'b0;
        model_reset();
        test_reset();
        test_load_hold();
        test_shift_seq();
        test_se_gap();
        test_continuous();
        test_async_reset_mid_shift();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
